hpm_counter_bank: RTL and testbench
===================================

Name: hpm_counter_bank

Overview:
Parametrised hardware performance-monitor bank that supersedes the fixed 6-counter block. It provides NumCounters mhpmcounter/mhpmevent pairs and multi-increment events, so several commit ports can add up to 2^IncWidth-1 per cycle. It implements Sscofpmf-style overflow (OF sticky bit, LCOFI pulse, scountovf mirror) and per-privilege inhibit filtering. It sits beside csr_regfile and is driven by the CSR SRAM-like port plus pre-encoded event sources.

Parameters:
NumCounters, 6, implemented counters mapped to hpm index 3..NumCounters+2 (1..29).
NumEvents, 32, selectable event sources; event 0 is hardwired "none".
IncWidth, 2, width of each per-event increment (max add per cycle = 2^IncWidth-1).
CntWidth, 64, counter width (33..64).
XLEN, 64, CSR data width (32 or 64).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
addr_i  in  12  CSR address
we_i  in  1  CSR write strobe
data_i  in  XLEN  CSR write data
data_o  out  XLEN  CSR read data (combinational from _q state)
access_error_o  out  1  illegal access this cycle
event_i  in  NumEvents x IncWidth  per-event increment amount this cycle
mcountinhibit_i  in  32  bit k inhibits hpm counter k
priv_lvl_i  in  2  current privilege (M=3, S=1, U=0)
stop_count_i  in  1  freeze all counters (debug mode with dcsr.stopcount)
scountovf_o  out  32  bit k = OF of counter k; bits 0..2 and unimplemented bits are 0
lcofi_o  out  1  one-cycle pulse when any OF bit goes 0->1 by hardware

Behaviour:
- Reset: all counters 0, all mhpmevent 0, data_o 0, access_error_o 0, scountovf_o 0, lcofi_o 0. Reset asserted mid-operation clears all state immediately.
- mhpmevent fields: [7:0] EVSEL, [60] UINH, [61] SINH, [62] MINH, [63] OF. All other bits read 0.
- When XLEN=32, bits [63:32] are accessed via mhpmeventNh (0x723+).
- Counter k (k=3..NumCounters+2) per cycle:
  - inc = event_i[EVSEL] zero-extended.
  - inc = 0 if EVSEL=0, EVSEL>=NumEvents, mcountinhibit_i[k], stop_count_i, or the INH bit matching priv_lvl_i is set.
  - Next value = cnt + inc, modulo 2^CntWidth.
  - Carry-out sets OF. If OF was 0, lcofi_o pulses the next cycle (registered). Several counters overflowing together give a single pulse.
- CSR write, registered, effective the next cycle:
  - mhpmcounterN 0xB03+: low XLEN bits.
  - mhpmcounterNh 0xB83+: XLEN=32 only; upper CntWidth-32 bits.
  - mhpmeventN 0x323+ and mhpmeventNh 0x723+: only defined fields are written.
  - A write to counter k suppresses increment and OF-set for k in that cycle only. Other counters keep counting. (The old block stalled all counters on any write; that behaviour is removed.)
  - Event write of OF=0 coinciding with a hardware overflow: hardware set wins, OF=1, lcofi pulses.
  - A software write of OF=1 never pulses lcofi_o.
- CSR read, same-cycle: mhpmcounter/h, mhpmevent/h, hpmcounter 0xC03+, hpmcounterh 0xC83+. Values are pre-update (_q). Counter bits above CntWidth read 0.
- Address inside a 3..31 window but above NumCounters+2: reads 0, writes ignored, no error.
- access_error_o=1 (comb):
  - any *h address with XLEN=64;
  - we_i to 0xC03..0xC1F or 0xC83..0xC9F.
  - State is unchanged on error.
- Access to addresses outside all windows: data_o=0, no error (owned by csr_regfile).

Decomposition:
- hpm_pkg holds: CSR base constants (0xB03, 0xB83, 0x323, 0x723, 0xC03, 0xC83), mhpmevent_t packed struct (of, minh, sinh, uinh, evsel), and field bit positions.
- Sub-module hpm_counter: one counter plus its event register, increment mux, inhibit filter, carry/OF logic and write override. Instantiated NumCounters times by generate.
- The top level does address decode, read mux, the lcofi register and scountovf assembly.

Test Plan:
- Count and inhibit:
  - mhpmevent3=5, event_i[5]=2 for 10 cycles -> mhpmcounter3 reads 20.
  - Set mcountinhibit_i[3] -> counter holds 20.
- Overflow:
  - Write mhpmcounter4=0xFFFF_FFFF_FFFF_FFFE, event3 increments by 3 -> counter=1, OF=1, scountovf_o[4]=1, lcofi_o high exactly 1 cycle.
  - Further overflow with OF still 1 -> no pulse.
- Privilege filter: mhpmevent5 with MINH=1, priv_lvl_i=3 with active event -> no count; priv_lvl_i=0 -> counts.
- Write priority: write mhpmcounter3=100 while counters 3 and 4 count +1 -> next cycle counter3=100, counter4 advanced by 1.
- Access errors:
  - XLEN=64, read 0xB83 -> access_error_o=1, data_o=0.
  - Write 0xC03 -> error, counter3 unchanged.
  - Read 0xB1F with NumCounters=6 -> 0, no error.
- Reset mid-count: assert rst_ni low during counting with OF=1 -> all counters, events and scountovf_o read 0 afterwards.

Source files
------------

// File: rtl/hpm_pkg.sv
// Shared CSR address map, mhpmevent layout and small helpers for the HPM counter bank.
package hpm_pkg;

    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMEVENT3H   = 12'h723;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;

    localparam int unsigned EVSEL_W   = 8;
    localparam int unsigned UINH_BIT  = 60;
    localparam int unsigned SINH_BIT  = 61;
    localparam int unsigned MINH_BIT  = 62;
    localparam int unsigned OF_BIT    = 63;

    typedef struct packed {
        logic                of;
        logic                minh;
        logic                sinh;
        logic                uinh;
        logic [EVSEL_W-1:0]  evsel;
    } mhpmevent_t;

    function automatic logic [63:0] evt_to_csr(input mhpmevent_t e);
        logic [63:0] r;
        r = '0;
        r[EVSEL_W-1:0] = e.evsel;
        r[UINH_BIT]    = e.uinh;
        r[SINH_BIT]    = e.sinh;
        r[MINH_BIT]    = e.minh;
        r[OF_BIT]      = e.of;
        return r;
    endfunction

    function automatic mhpmevent_t csr_to_evt(input logic [63:0] d);
        mhpmevent_t e;
        e.evsel = d[EVSEL_W-1:0];
        e.uinh  = d[UINH_BIT];
        e.sinh  = d[SINH_BIT];
        e.minh  = d[MINH_BIT];
        e.of    = d[OF_BIT];
        return e;
    endfunction

    // Every window starts at index 3 of a 32-entry aligned block.
    function automatic logic in_window(input logic [11:0] addr, input logic [11:0] base);
        return (addr[11:5] == base[11:5]) && (addr[4:0] >= 5'd3);
    endfunction

endpackage

// File: rtl/hpm_counter.sv
// One mhpmcounter/mhpmevent pair: event select, inhibit filter, add with carry, OF and CSR writes.
module hpm_counter
    import hpm_pkg::*;
#(
    parameter int unsigned NumEvents = 32,
    parameter int unsigned IncWidth  = 2,
    parameter int unsigned CntWidth  = 64,
    parameter int unsigned XLEN      = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumEvents-1:0][IncWidth-1:0] event_i,
    input  logic                               inhibit,
    input  logic                               stop_count,
    input  logic [1:0]                         priv_lvl,
    input  logic                               cnt_we_lo,
    input  logic                               cnt_we_hi,
    input  logic                               evt_we_lo,
    input  logic                               evt_we_hi,
    input  logic [XLEN-1:0]                    wdata,
    output logic [CntWidth-1:0]                cnt,
    output mhpmevent_t                         evt,
    output logic                               of_set
);

    localparam int unsigned SumW   = CntWidth + 1;
    localparam logic [63:0] LoMask = 64'({XLEN{1'b1}});
    localparam logic [63:0] HiMask = ~LoMask;

    logic [CntWidth-1:0] cnt_q, cnt_d;
    mhpmevent_t          evt_q, evt_d;
    logic [IncWidth-1:0] inc;
    logic                priv_inh, cnt_wr, hw_ovf;
    logic [SumW-1:0]     sum;
    logic [63:0]         cnt_merged, evt_merged;

    // Low write covers XLEN bits; high write (XLEN=32 only) covers bits 63:32.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic lo, input logic hi,
                                          input logic [XLEN-1:0] d);
        logic [63:0] r;
        r = old;
        if (lo) r = (r & ~LoMask) | (64'(d) & LoMask);
        if (hi) r = (r & ~HiMask) | ((64'(d) << 32) & HiMask);
        return r;
    endfunction

    always_comb begin
        inc = '0;
        for (int e = 1; e < int'(NumEvents); e++) begin
            if (evt_q.evsel == 8'(e)) inc = event_i[e];
        end
        case (priv_lvl)
            2'd3:    priv_inh = evt_q.minh;
            2'd1:    priv_inh = evt_q.sinh;
            2'd0:    priv_inh = evt_q.uinh;
            default: priv_inh = 1'b0;
        endcase
        if (inhibit || stop_count || priv_inh) inc = '0;

        sum        = {1'b0, cnt_q} + SumW'(inc);
        cnt_wr     = cnt_we_lo | cnt_we_hi;
        hw_ovf     = sum[CntWidth] & ~cnt_wr;
        cnt_merged = merge(64'(cnt_q), cnt_we_lo, cnt_we_hi, wdata);
        cnt_d      = cnt_wr ? cnt_merged[CntWidth-1:0] : sum[CntWidth-1:0];

        evt_merged = merge(evt_to_csr(evt_q), evt_we_lo, evt_we_hi, wdata);
        evt_d      = (evt_we_lo || evt_we_hi) ? csr_to_evt(evt_merged) : evt_q;
        // Hardware overflow beats a coincident software clear of OF.
        if (hw_ovf) evt_d.of = 1'b1;
        of_set     = hw_ovf & ~evt_q.of;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign cnt = cnt_q;
    assign evt = evt_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Parametrised HPM bank: CSR decode, read mux, scountovf mirror and LCOFI pulse.
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int unsigned NumCounters = 6,
    parameter int unsigned NumEvents   = 32,
    parameter int unsigned IncWidth    = 2,
    parameter int unsigned CntWidth    = 64,
    parameter int unsigned XLEN        = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [11:0]                        addr_i,
    input  logic                               we_i,
    input  logic [XLEN-1:0]                    data_i,
    output logic [XLEN-1:0]                    data_o,
    output logic                               access_error_o,
    input  logic [NumEvents-1:0][IncWidth-1:0] event_i,
    input  logic [31:0]                        mcountinhibit_i,
    input  logic [1:0]                         priv_lvl_i,
    input  logic                               stop_count_i,
    output logic [31:0]                        scountovf_o,
    output logic                               lcofi_o
);

    logic [NumCounters-1:0][CntWidth-1:0] cnt;
    mhpmevent_t [NumCounters-1:0]         evt;
    logic [NumCounters-1:0]               of_set;

    logic [4:0]  idx;
    logic        is_cnt, is_cnth, is_evt, is_evth, is_ucnt, is_ucnth;
    logic        implemented, wr_ok, rd_hi;
    logic [63:0] rd64;
    logic        lcofi_q;

    always_comb begin
        idx         = addr_i[4:0];
        is_cnt      = in_window(addr_i, CSR_MHPMCOUNTER3);
        is_cnth     = in_window(addr_i, CSR_MHPMCOUNTER3H);
        is_evt      = in_window(addr_i, CSR_MHPMEVENT3);
        is_evth     = in_window(addr_i, CSR_MHPMEVENT3H);
        is_ucnt     = in_window(addr_i, CSR_HPMCOUNTER3);
        is_ucnth    = in_window(addr_i, CSR_HPMCOUNTER3H);
        implemented = 32'(idx) < 32'(NumCounters + 3);

        access_error_o = ((XLEN == 64) && (is_cnth || is_evth || is_ucnth)) ||
                         (we_i && (is_ucnt || is_ucnth));
        wr_ok = we_i && !access_error_o && implemented;

        rd64  = '0;
        rd_hi = is_cnth || is_evth || is_ucnth;
        for (int i = 0; i < int'(NumCounters); i++) begin
            if (idx == 5'(i + 3)) begin
                if (is_cnt || is_cnth || is_ucnt || is_ucnth) rd64 = 64'(cnt[i]);
                if (is_evt || is_evth)                        rd64 = evt_to_csr(evt[i]);
            end
        end
        if (access_error_o)  data_o = '0;
        else if (rd_hi)      data_o = XLEN'(rd64 >> 32);
        else                 data_o = XLEN'(rd64);
    end

    for (genvar i = 0; i < int'(NumCounters); i++) begin : g_cnt
        logic hit;
        assign hit = wr_ok && (idx == 5'(i + 3));

        hpm_counter #(
            .NumEvents (NumEvents),
            .IncWidth  (IncWidth),
            .CntWidth  (CntWidth),
            .XLEN      (XLEN)
        ) u_cnt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .event_i    (event_i),
            .inhibit    (mcountinhibit_i[i+3]),
            .stop_count (stop_count_i),
            .priv_lvl   (priv_lvl_i),
            .cnt_we_lo  (hit && is_cnt),
            .cnt_we_hi  (hit && is_cnth),
            .evt_we_lo  (hit && is_evt),
            .evt_we_hi  (hit && is_evth),
            .wdata      (data_i),
            .cnt        (cnt[i]),
            .evt        (evt[i]),
            .of_set     (of_set[i])
        );
    end

    always_comb begin
        scountovf_o = '0;
        for (int i = 0; i < int'(NumCounters); i++) scountovf_o[i+3] = evt[i].of;
    end

    // Many counters overflowing in one cycle collapse into one pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lcofi_q <= 1'b0;
        else         lcofi_q <= |of_set;
    end

    assign lcofi_o = lcofi_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised plus directed check of hpm_counter_bank against a behavioural model.
module tb_hpm_counter_bank;

    localparam int NC = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [11:0]      addr;
    logic             we;
    logic [63:0]      wdata;
    logic [63:0]      rdata;
    logic             err;
    logic [31:0][1:0] ev;
    logic [31:0]      inh;
    logic [1:0]       priv;
    logic             stop;
    logic [31:0]      sovf;
    logic             lcofi;

    int n_vec = 0;
    int n_err = 0;

    hpm_counter_bank dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .addr_i          (addr),
        .we_i            (we),
        .data_i          (wdata),
        .data_o          (rdata),
        .access_error_o  (err),
        .event_i         (ev),
        .mcountinhibit_i (inh),
        .priv_lvl_i      (priv),
        .stop_count_i    (stop),
        .scountovf_o     (sovf),
        .lcofi_o         (lcofi)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    longint unsigned m_cnt [NC];
    bit [7:0]        m_sel [NC];
    bit              m_u [NC], m_s [NC], m_m [NC], m_of [NC];
    bit              m_lcofi;

    // 0 none, 1 mhpmcounter, 2 mhpmcounterh, 3 mhpmevent, 4 mhpmeventh, 5 hpmcounter, 6 hpmcounterh
    function automatic int kind_of(input logic [11:0] a);
        if (a[4:0] < 5'd3) return 0;
        case (a & 12'hFE0)
            12'hB00: return 1;
            12'hB80: return 2;
            12'h320: return 3;
            12'h720: return 4;
            12'hC00: return 5;
            12'hC80: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_err(input logic [11:0] a, input logic w);
        int k;
        k = kind_of(a);
        return (k == 2 || k == 4 || k == 6) || (w && (k == 5 || k == 6));
    endfunction

    function automatic logic [63:0] exp_rd(input logic [11:0] a, input logic w);
        int k, n;
        k = kind_of(a);
        n = int'(a[4:0]) - 3;
        if (exp_err(a, w) || n >= NC || k == 0) return 64'd0;
        if (k == 3) return {m_of[n], m_m[n], m_s[n], m_u[n], 52'd0, m_sel[n]};
        return m_cnt[n];
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: advances on each clock edge, clears immediately on reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < NC; k++) begin
                    m_cnt[k] = 0; m_sel[k] = 0; m_u[k] = 0; m_s[k] = 0; m_m[k] = 0; m_of[k] = 0;
                end
                m_lcofi = 0;
            end else begin
                bit any;
                int kd, n;
                bit e;
                kd  = kind_of(addr);
                n   = int'(addr[4:0]);
                e   = exp_err(addr, we);
                any = 0;
                for (int k = 0; k < NC; k++) begin
                    longint unsigned inc, nv;
                    bit pinh, hw, old_of;
                    old_of = m_of[k];
                    inc = 0;
                    if (m_sel[k] >= 1 && m_sel[k] < 32) inc = longint'(ev[m_sel[k]]);
                    pinh = (priv == 3 && m_m[k]) || (priv == 1 && m_s[k]) || (priv == 0 && m_u[k]);
                    if (inh[k+3] || stop || pinh) inc = 0;
                    hw = 0;
                    if (we && !e && kd == 1 && n == k + 3) m_cnt[k] = wdata;
                    else begin
                        nv = m_cnt[k] + inc;
                        hw = nv < m_cnt[k];
                        m_cnt[k] = nv;
                    end
                    if (we && !e && kd == 3 && n == k + 3) begin
                        m_sel[k] = wdata[7:0];
                        m_u[k] = wdata[60]; m_s[k] = wdata[61]; m_m[k] = wdata[62]; m_of[k] = wdata[63];
                    end
                    if (hw) begin
                        if (!old_of) any = 1;
                        m_of[k] = 1;
                    end
                end
                m_lcofi = any;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] so;
        so = '0;
        for (int k = 0; k < NC; k++) so[k+3] = m_of[k];
        chk("data_o", rdata, exp_rd(addr, we));
        chk("access_error_o", 64'(err), 64'(exp_err(addr, we)));
        chk("scountovf_o", 64'(sovf), 64'(so));
        chk("lcofi_o", 64'(lcofi), 64'(m_lcofi));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        addr = a; we = 1'b1; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [63:0] exp);
        addr = a; we = 1'b0;
        @(negedge clk);
        chk(nm, rdata, exp);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; addr = 12'hB03; we = 1'b0; wdata = '0;
        ev = '0; inh = '0; priv = 2'd3; stop = 1'b0;
        @(negedge clk);
        chk("reset data_o", rdata, 64'd0);
        chk("reset scountovf", 64'(sovf), 64'd0);
        chk("reset lcofi", 64'(lcofi), 64'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Count and inhibit
        wr(12'h323, 64'd5);
        ev[5] = 2'd2;
        repeat (10) tick();
        ev[5] = 2'd0;
        rd_chk("count 20", 12'hB03, 64'd20);
        inh[3] = 1'b1; ev[5] = 2'd2;
        repeat (5) tick();
        rd_chk("inhibit hold", 12'hB03, 64'd20);
        inh = '0; ev = '0;

        // Overflow
        wr(12'h324, 64'd3);
        wr(12'hB04, 64'hFFFF_FFFF_FFFF_FFFE);
        ev[3] = 2'd3;
        tick();
        ev[3] = 2'd0;
        addr = 12'hB04;
        @(negedge clk);
        chk("ovf wrap", rdata, 64'd1);
        chk("ovf scountovf4", 64'(sovf[4]), 64'd1);
        chk("ovf lcofi on", 64'(lcofi), 64'd1);
        tick();
        @(negedge clk);
        chk("ovf lcofi off", 64'(lcofi), 64'd0);
        tick();
        rd_chk("ovf event OF", 12'h324, 64'h8000_0000_0000_0003);
        wr(12'hB04, 64'hFFFF_FFFF_FFFF_FFFF);
        ev[3] = 2'd1;
        tick();
        ev[3] = 2'd0;
        @(negedge clk);
        chk("ovf again no pulse", 64'(lcofi), 64'd0);
        tick();

        // Privilege filter
        wr(12'h325, (64'd1 << 62) | 64'd7);
        priv = 2'd3; ev[7] = 2'd1;
        repeat (4) tick();
        ev[7] = 2'd0;
        rd_chk("minh no count", 12'hB05, 64'd0);
        priv = 2'd0; ev[7] = 2'd1;
        repeat (4) tick();
        ev[7] = 2'd0;
        rd_chk("user counts", 12'hB05, 64'd4);

        // Write priority: counter 3 written, counter 4 keeps counting
        ev[5] = 2'd1; ev[3] = 2'd1;
        wr(12'hB03, 64'd100);
        ev = '0;
        rd_chk("write wins", 12'hB03, 64'd100);
        rd_chk("neighbour counts", 12'hB04, 64'd1);

        // Access errors
        addr = 12'hB83; we = 1'b0;
        @(negedge clk);
        chk("h addr error", 64'(err), 64'd1);
        chk("h addr data", rdata, 64'd0);
        tick();
        addr = 12'hC03; we = 1'b1; wdata = 64'd5;
        @(negedge clk);
        chk("user write error", 64'(err), 64'd1);
        tick();
        we = 1'b0;
        rd_chk("user write ignored", 12'hB03, 64'd100);
        addr = 12'hB1F;
        @(negedge clk);
        chk("unimpl data", rdata, 64'd0);
        chk("unimpl error", 64'(err), 64'd0);
        tick();

        // Reset mid-count with OF set
        ev[5] = 2'd1;
        repeat (3) tick();
        addr = 12'hB03;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset scountovf", 64'(sovf), 64'd0);
        chk("mid reset cnt", rdata, 64'd0);
        tick();
        rst_n = 1'b1; ev = '0;
        rd_chk("post reset event", 12'h324, 64'd0);
        rd_chk("post reset cnt4", 12'hB04, 64'd0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            logic [11:0] alist [20];
            alist = '{12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB07, 12'hB08, 12'hB09, 12'hB1F,
                      12'hB02, 12'h323, 12'h324, 12'h325, 12'h326, 12'h328, 12'h33F,
                      12'hC03, 12'hC08, 12'hB83, 12'h723, 12'hC83};
            addr = alist[$urandom_range(0, 19)];
            we   = ($urandom_range(0, 3) == 0);
            if (kind_of(addr) == 3)
                wdata = {$urandom_range(0, 15) == 0 ? 4'($urandom) : 4'($urandom) & 4'h7,
                         52'($urandom), 8'($urandom_range(0, 40))};
            else if ($urandom_range(0, 1) == 0)
                wdata = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            else
                wdata = {$urandom, $urandom};
            for (int e = 0; e < 32; e++) ev[e] = 2'($urandom);
            inh  = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            priv = 2'($urandom);
            stop = ($urandom_range(0, 15) == 0);
            tick();
        end
        we = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
